serial_addsub_digit: RTL and testbench
======================================

# serial_addsub_digit

Parametrised serial adder/subtractor that consumes one DIGIT_W-bit digit pair per valid beat, LSB digit first, and emits one registered sum digit per beat. It extends the 1-bit serial adder with:
- configurable digit width;
- per-word add/subtract mode;
- a registered output valid;
- end-of-word status flags (carry, signed overflow, zero);
- a word-length guard.

It sits between serial operand sources and a serial result sink in the datapath.

## Interface
Parameters:
- DIGIT_W, 1, bits per beat (≥1)
- MAX_BEATS, 16, maximum beats per word (≥1); counter width $clog2(MAX_BEATS+1)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- vld  input  1  input beat valid
- sub  input  1  mode: 0 add, 1 subtract (a − b); sampled on first beat of word only
- a  input  DIGIT_W  operand A digit
- b  input  DIGIT_W  operand B digit
- last  input  1  final digit of word; ignored when vld=0
- sum_vld  output  1  registered output beat valid
- sum  output  DIGIT_W  registered result digit
- sum_last  output  1  output beat ends a word
- carry_out  output  1  final carry out of the word's MSB (sub: 1 = no borrow); valid only with sum_vld&sum_last, else 0
- overflow  output  1  signed overflow of the word; valid only with sum_vld&sum_last, else 0
- zero  output  1  every sum digit of the word was 0; valid only with sum_vld&sum_last, else 0
- length_err  output  1  word forcibly terminated at MAX_BEATS; valid only with sum_vld&sum_last, else 0

## Operation
- State:
  - carry (1b)
  - mode (1b)
  - in_word (1b)
  - beat_cnt
  - zero_acc (1b)
- First beat: any vld beat with in_word=0.
  - On the first beat: effective mode = sub input, carry-in = sub.
  - On later beats: effective mode = stored mode, carry-in = stored carry.
- Per beat: b_eff = mode ? ~b : b. The beat computes {c_out, s} = a + b_eff + cin at DIGIT_W+1 bits. c_msb_in is the carry into bit DIGIT_W−1.
- Non-terminating beat:
  - carry ← c_out
  - mode latched
  - in_word ← 1
  - beat_cnt += 1
  - zero_acc ← zero_acc_eff & (s==0); zero_acc_eff is 1 on the first beat, otherwise stored zero_acc.
- Terminating beat: vld & (last | beat_cnt==MAX_BEATS−1).
  - Outputs: sum_last=1, carry_out=c_out, overflow=c_out^c_msb_in, zero=zero_acc_eff&(s==0).
  - length_err=1 only if last=0.
  - State clears: carry=0, in_word=0, beat_cnt=0, zero_acc=1.
  - The next vld beat starts a new word.
- Single-beat word (first and last in the same beat) is legal and yields all flags from that beat.
- vld=0: no state change, last and sub ignored, sum_vld=0; sum holds its previous value.
- sub mid-word is ignored; the mode is fixed for the whole word.
- rst has priority over vld. Reset mid-word discards the partial word; no sum_last is emitted for it.

## Timing
- Latency 1 cycle: a beat accepted at edge t produces sum_vld=1 with sum/flags in cycle t+1.
- No backpressure; one beat per cycle sustained, arbitrary vld gaps allowed.
- Reset values: all outputs 0; carry=0, mode=0, in_word=0, beat_cnt=0, zero_acc=1.
- After reset is released, the first vld beat is a first beat.
- Back-to-back words: a beat following a terminating beat in the next cycle is a first beat with no bubble.

## Test plan
- DIGIT_W=1, add 3+5 over 4 beats: a=1,1,0,0 and b=1,0,1,0, last on beat 4. Required: sum=0,0,0,1 (8), final beat carry_out=0, overflow=1, zero=0, length_err=0.
- DIGIT_W=4, single beat a=5, b=5, sub=1, last=1. Required next cycle: sum=0, sum_last=1, zero=1, carry_out=1, overflow=0.
- Repeat the first scenario with vld low for 2 cycles between every beat, and toggle a/b/last/sub during the gaps. Required: identical sum sequence and flags; sum_vld=0 in gap cycles.
- DIGIT_W=1, MAX_BEATS=4, 6 vld beats of a=1, b=0, last=0 throughout. Required:
  - beat 4 output: sum_last=1, length_err=1;
  - beats 5–6 start a new word with carry-in 0;
  - no flags on those beats.
- DIGIT_W=2, sub=1 on beat 1 and sub=0 on beat 2, a=2'b00,2'b01 and b=2'b01,2'b00 (4−1). Required: sum=2'b11,2'b00 (3), carry_out=1, overflow=0.
- Assert rst for one cycle after 2 beats of a word, then run a fresh 1-beat add a=1, b=1 (DIGIT_W=2). Required:
  - all outputs 0 during the reset cycle;
  - fresh word: sum=2, carry_out=0, no stale carry.

Source files
------------

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor, LSB digit first, one registered result
// digit per valid beat with end-of-word carry/overflow/zero/length flags.
module serial_addsub_digit #(
   parameter int DIGIT_W   = 1,
   parameter int MAX_BEATS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic               sub,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               last,
   output logic               sum_vld,
   output logic [DIGIT_W-1:0] sum,
   output logic               sum_last,
   output logic               carry_out,
   output logic               overflow,
   output logic               zero,
   output logic               length_err
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

   logic          carry;
   logic          mode;
   logic          in_word;
   logic [CW-1:0] beat_cnt;
   logic          zero_acc;

   logic               first;
   logic               mode_eff;
   logic               cin;
   logic               zacc_eff;
   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W:0]   full;
   logic [DIGIT_W-1:0] s;
   logic               c_out;
   logic               c_msb_in;
   logic               s_zero;
   logic               term;

   always_comb begin
      first    = ~in_word;
      mode_eff = first ? sub : mode;
      cin      = first ? sub : carry;
      zacc_eff = first | zero_acc;
      b_eff    = mode_eff ? ~b : b;
      full     = {1'b0, a} + {1'b0, b_eff}
               + {{DIGIT_W{1'b0}}, cin};
      s        = full[DIGIT_W-1:0];
      c_out    = full[DIGIT_W];
      // carry into the MSB recovered from the MSB sum bit
      c_msb_in = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1]
               ^ s[DIGIT_W-1];
      s_zero   = (s == '0);
      term     = vld & (last | (beat_cnt == LAST_CNT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry      <= 1'b0;
         mode       <= 1'b0;
         in_word    <= 1'b0;
         beat_cnt   <= '0;
         zero_acc   <= 1'b1;
         sum_vld    <= 1'b0;
         sum        <= '0;
         sum_last   <= 1'b0;
         carry_out  <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
         length_err <= 1'b0;
      end else begin
         sum_vld    <= vld;
         sum_last   <= term;
         carry_out  <= term & c_out;
         overflow   <= term & (c_out ^ c_msb_in);
         zero       <= term & zacc_eff & s_zero;
         length_err <= term & ~last;
         if (vld) begin
            sum <= s;
            if (term) begin
               carry    <= 1'b0;
               in_word  <= 1'b0;
               beat_cnt <= '0;
               zero_acc <= 1'b1;
            end else begin
               carry    <= c_out;
               mode     <= mode_eff;
               in_word  <= 1'b1;
               beat_cnt <= beat_cnt + CW'(1);
               zero_acc <= zacc_eff & s_zero;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Bench for serial_addsub_digit: directed scenarios on four parameterisations
// plus random traffic checked against a word-level arithmetic model.
module tb_serial_addsub_digit;

   localparam int DWS [4] = '{1, 1, 2, 4};
   localparam int MBS [4] = '{16, 4, 16, 16};

   logic       clk = 1'b0;
   logic       rst, vld, sub, last;
   logic [3:0] a_in, b_in;

   logic       sv [4], sl [4], co [4], ov [4], zr [4], le [4];
   logic [0:0] sum0, sum1;
   logic [1:0] sum2;
   logic [3:0] sum3;
   logic [3:0] sum_x [4];

   int errors = 0;
   int checks = 0;

   logic [127:0] ma [4], mb [4];
   int           mk [4];
   bit           mmode [4], min_w [4];
   logic         e_sv [4], e_sl [4], e_co [4], e_ov [4], e_zr [4], e_le [4];
   logic [3:0]   e_sum [4];

   always #5 clk = ~clk;

   assign sum_x[0] = {3'b000, sum0};
   assign sum_x[1] = {3'b000, sum1};
   assign sum_x[2] = {2'b00, sum2};
   assign sum_x[3] = sum3;

   serial_addsub_digit #(.DIGIT_W(1), .MAX_BEATS(16)) u0 (
      .clk(clk), .rst(rst), .vld(vld), .sub(sub),
      .a(a_in[0:0]), .b(b_in[0:0]), .last(last),
      .sum_vld(sv[0]), .sum(sum0), .sum_last(sl[0]),
      .carry_out(co[0]), .overflow(ov[0]), .zero(zr[0]),
      .length_err(le[0]));

   serial_addsub_digit #(.DIGIT_W(1), .MAX_BEATS(4)) u1 (
      .clk(clk), .rst(rst), .vld(vld), .sub(sub),
      .a(a_in[0:0]), .b(b_in[0:0]), .last(last),
      .sum_vld(sv[1]), .sum(sum1), .sum_last(sl[1]),
      .carry_out(co[1]), .overflow(ov[1]), .zero(zr[1]),
      .length_err(le[1]));

   serial_addsub_digit #(.DIGIT_W(2), .MAX_BEATS(16)) u2 (
      .clk(clk), .rst(rst), .vld(vld), .sub(sub),
      .a(a_in[1:0]), .b(b_in[1:0]), .last(last),
      .sum_vld(sv[2]), .sum(sum2), .sum_last(sl[2]),
      .carry_out(co[2]), .overflow(ov[2]), .zero(zr[2]),
      .length_err(le[2]));

   serial_addsub_digit #(.DIGIT_W(4), .MAX_BEATS(16)) u3 (
      .clk(clk), .rst(rst), .vld(vld), .sub(sub),
      .a(a_in), .b(b_in), .last(last),
      .sum_vld(sv[3]), .sum(sum3), .sum_last(sl[3]),
      .carry_out(co[3]), .overflow(ov[3]), .zero(zr[3]),
      .length_err(le[3]));

   // Word-level reference: operands accumulated as integers, result
   // digits and flags taken from ordinary wide add/subtract.
   task automatic model_step(input int i);
      int dw, w;
      logic [127:0] dm, m, beff, r;
      logic signed [129:0] sa, sb, t, lim;
      bit term;
      dw = DWS[i];
      if (rst) begin
         min_w[i] = 0; mk[i] = 0; mmode[i] = 0;
         e_sv[i] = 0; e_sl[i] = 0; e_co[i] = 0;
         e_ov[i] = 0; e_zr[i] = 0; e_le[i] = 0;
         e_sum[i] = 4'd0;
      end else begin
         e_sv[i] = vld; e_sl[i] = 0; e_co[i] = 0;
         e_ov[i] = 0; e_zr[i] = 0; e_le[i] = 0;
         if (vld) begin
            if (!min_w[i]) begin
               mmode[i] = sub; mk[i] = 0;
               ma[i] = '0; mb[i] = '0;
            end
            dm = (128'd1 << dw) - 128'd1;
            ma[i] = ma[i] | (({124'd0, a_in} & dm) << (mk[i] * dw));
            mb[i] = mb[i] | (({124'd0, b_in} & dm) << (mk[i] * dw));
            w = (mk[i] + 1) * dw;
            m = (128'd1 << w) - 128'd1;
            beff = mmode[i] ? (~mb[i] & m) : mb[i];
            r = ma[i] + beff + {127'd0, mmode[i]};
            e_sum[i] = 4'((r >> (mk[i] * dw)) & dm);
            term = last || (mk[i] == MBS[i] - 1);
            if (term) begin
               e_sl[i] = 1;
               e_co[i] = r[w];
               e_zr[i] = ((r & m) == '0);
               e_le[i] = !last;
               sa = $signed({2'b00, ma[i]});
               sb = $signed({2'b00, mb[i]});
               if (ma[i][w-1]) sa = sa - (130'sd1 <<< w);
               if (mb[i][w-1]) sb = sb - (130'sd1 <<< w);
               t = mmode[i] ? sa - sb : sa + sb;
               lim = 130'sd1 <<< (w - 1);
               e_ov[i] = (t >= lim) || (t < -lim);
               min_w[i] = 0;
            end else begin
               min_w[i] = 1;
               mk[i] = mk[i] + 1;
            end
         end
      end
   endtask

   task automatic cycle(input logic r, input logic v, input logic s,
                        input logic [3:0] aa, input logic [3:0] bb,
                        input logic l);
      rst = r; vld = v; sub = s; a_in = aa; b_in = bb; last = l;
      for (int i = 0; i < 4; i++) model_step(i);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cycle(1, 1, 1, 4'hf, 4'hf, 1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({sv[i], sl[i], co[i], ov[i], zr[i], le[i], sum_x[i]} !== 10'd0) begin
            errors++;
            $display("FAIL reset inst%0d: got %b%b%b%b%b%b sum=%h, want all 0",
                     i, sv[i], sl[i], co[i], ov[i], zr[i], le[i], sum_x[i]);
         end
      end
   endtask

   task automatic test_add_3_5(input int gap);
      logic [3:0] av [4] = '{4'd1, 4'd1, 4'd0, 4'd0};
      logic [3:0] bv [4] = '{4'd1, 4'd0, 4'd1, 4'd0};
      logic [3:0] ev [4] = '{4'd0, 4'd0, 4'd0, 4'd1};
      cycle(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         cycle(0, 1, 0, av[k], bv[k], k == 3);
         checks++;
         if (sv[0] !== 1'b1 || sum_x[0] !== ev[k] || sl[0] !== (k == 3)) begin
            errors++;
            $display("FAIL add35 gap%0d beat%0d: vld=%b sum=%h last=%b, want 1 %h %b",
                     gap, k, sv[0], sum_x[0], sl[0], ev[k], k == 3);
         end
         if (k == 3) begin
            checks++;
            if ({co[0], ov[0], zr[0], le[0]} !== 4'b0100) begin
               errors++;
               $display("FAIL add35 flags gap%0d: co/ov/zr/le=%b%b%b%b, want 0100",
                        gap, co[0], ov[0], zr[0], le[0]);
            end
         end
         for (int g = 0; g < gap; g++) begin
            cycle(0, 0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            checks++;
            if (sv[0] !== 1'b0 || sum_x[0] !== ev[k] || sl[0] !== 1'b0) begin
               errors++;
               $display("FAIL add35 gap cycle beat%0d: vld=%b sum=%h last=%b, want 0 %h 0",
                        k, sv[0], sum_x[0], sl[0], ev[k]);
            end
         end
      end
   endtask

   task automatic test_single_sub;
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 4'd5, 4'd5, 1);
      checks++;
      if (sum_x[3] !== 4'd0 || {sv[3], sl[3], zr[3], co[3], ov[3], le[3]} !== 6'b111100) begin
         errors++;
         $display("FAIL single_sub: sum=%h vld/last/zr/co/ov/le=%b%b%b%b%b%b, want 0 111100",
                  sum_x[3], sv[3], sl[3], zr[3], co[3], ov[3], le[3]);
      end
   endtask

   task automatic test_length_guard;
      cycle(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         cycle(0, 1, 0, 4'd1, 4'd0, 0);
         checks++;
         if (k == 3) begin
            if (sum_x[1] !== 4'd1 || {sl[1], le[1], co[1], ov[1], zr[1]} !== 5'b11000) begin
               errors++;
               $display("FAIL length beat%0d: sum=%h last/le/co/ov/zr=%b%b%b%b%b, want 1 11000",
                        k, sum_x[1], sl[1], le[1], co[1], ov[1], zr[1]);
            end
         end else if (sum_x[1] !== 4'd1 || {sl[1], le[1], co[1], ov[1], zr[1]} !== 5'b00000) begin
            errors++;
            $display("FAIL length beat%0d: sum=%h last/le/co/ov/zr=%b%b%b%b%b, want 1 00000",
                     k, sum_x[1], sl[1], le[1], co[1], ov[1], zr[1]);
         end
      end
   endtask

   task automatic test_mode_latch;
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 4'b00, 4'b01, 0);
      checks++;
      if (sum_x[2] !== 4'b0011 || sl[2] !== 1'b0) begin
         errors++;
         $display("FAIL latch beat0: sum=%h last=%b, want 3 0", sum_x[2], sl[2]);
      end
      cycle(0, 1, 0, 4'b01, 4'b00, 1);
      checks++;
      if (sum_x[2] !== 4'b0000 || {sl[2], co[2], ov[2]} !== 3'b110) begin
         errors++;
         $display("FAIL latch beat1: sum=%h last/co/ov=%b%b%b, want 0 110",
                  sum_x[2], sl[2], co[2], ov[2]);
      end
   endtask

   task automatic test_reset_mid_word;
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 4'd3, 4'd3, 0);
      cycle(0, 1, 0, 4'd3, 4'd3, 0);
      cycle(1, 1, 0, 4'd3, 4'd3, 1);
      checks++;
      if ({sv[2], sl[2], co[2], ov[2], zr[2], le[2], sum_x[2]} !== 10'd0) begin
         errors++;
         $display("FAIL midreset: got %b%b%b%b%b%b sum=%h, want all 0",
                  sv[2], sl[2], co[2], ov[2], zr[2], le[2], sum_x[2]);
      end
      cycle(0, 1, 0, 4'd1, 4'd1, 1);
      checks++;
      if (sum_x[2] !== 4'd2 || {sv[2], sl[2], co[2], ov[2], zr[2], le[2]} !== 6'b110100) begin
         errors++;
         $display("FAIL fresh word: sum=%h vld/last/co/ov/zr/le=%b%b%b%b%b%b, want 2 110100",
                  sum_x[2], sv[2], sl[2], co[2], ov[2], zr[2], le[2]);
      end
   endtask

   task automatic test_back_to_back;
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 4'd3, 4'd4, 1);
      checks++;
      if (sum_x[3] !== 4'd7 || {sl[3], co[3]} !== 2'b10) begin
         errors++;
         $display("FAIL b2b word0: sum=%h last/co=%b%b, want 7 10", sum_x[3], sl[3], co[3]);
      end
      cycle(0, 1, 1, 4'd9, 4'd2, 1);
      checks++;
      if (sum_x[3] !== 4'd7 || {sl[3], co[3]} !== 2'b11) begin
         errors++;
         $display("FAIL b2b word1: sum=%h last/co=%b%b, want 7 11", sum_x[3], sl[3], co[3]);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(99) < 2, $urandom_range(99) < 70,
               1'($urandom), 4'($urandom), 4'($urandom),
               $urandom_range(99) < 20);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sv[i], sl[i], co[i], ov[i], zr[i], le[i], sum_x[i]} !==
                {e_sv[i], e_sl[i], e_co[i], e_ov[i], e_zr[i], e_le[i], e_sum[i]}) begin
               errors++;
               $display("FAIL random n%0d inst%0d: got %b%b%b%b%b%b sum=%h, want %b%b%b%b%b%b sum=%h",
                        n, i, sv[i], sl[i], co[i], ov[i], zr[i], le[i], sum_x[i],
                        e_sv[i], e_sl[i], e_co[i], e_ov[i], e_zr[i], e_le[i], e_sum[i]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; vld = 1'b0; sub = 1'b0; last = 1'b0;
      a_in = 4'd0; b_in = 4'd0;
      test_reset;
      test_add_3_5(0);
      test_add_3_5(2);
      test_single_sub;
      test_length_guard;
      test_mode_latch;
      test_reset_mid_word;
      test_back_to_back;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
